// File: rtl/serializer_pkg.sv
// Shared types and helpers for the 16-bit serial link transmitter.
// The SERIALIZER_PARITY_EN build option adds a trailing even-parity bit.
package serializer_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      PARITY
   } ser_state_t;

   localparam int SER_DATA_W = 16;

   function automatic int bit_count(input int mod, input int width);
      return (mod == 0) ? width : mod;
   endfunction

endpackage

// File: rtl/serializer.sv
// Parallel-to-serial transmitter, MSB first, with a per-bit ready stall.
// Define SERIALIZER_PARITY_EN to append one even-parity bit per word.
module serializer
   import serializer_pkg::*;
#(
   parameter int DATA_W = SER_DATA_W,
   parameter int MOD_W  = $clog2(DATA_W)
) (
   input  logic              clk_i,
   input  logic              arst_n_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [MOD_W-1:0]  data_mod_i,
   input  logic              data_val_i,
   input  logic              ser_ready_i,
   output logic              ser_data_o,
   output logic              ser_data_val_o,
   output logic              busy_o
);

   localparam int CNT_W = MOD_W + 1;

   ser_state_t        state;
   logic [DATA_W-1:0] shreg;
   logic [CNT_W-1:0]  cnt;
   logic              last;

`ifdef SERIALIZER_PARITY_EN
   logic              par;
`endif

   // Serial bit is always the shift register MSB; cleared whenever idle.
   assign ser_data_o = shreg[DATA_W-1];
   assign last       = (cnt == CNT_W'(1));

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state          <= IDLE;
         shreg          <= '0;
         cnt            <= '0;
         ser_data_val_o <= 1'b0;
         busy_o         <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
         par            <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (data_val_i) begin
                  state          <= SHIFT;
                  shreg          <= data_i;
                  cnt            <= CNT_W'(bit_count(int'(data_mod_i), DATA_W));
                  ser_data_val_o <= 1'b1;
                  busy_o         <= 1'b1;
`ifdef SERIALIZER_PARITY_EN
                  par            <= 1'b0;
`endif
               end
            end
            SHIFT: begin
               if (ser_ready_i) begin
                  if (cnt != '0) begin
                     cnt <= cnt - CNT_W'(1);
                  end
                  if (last) begin
`ifdef SERIALIZER_PARITY_EN
                     // Parity rides out through the MSB like a data bit.
                     state <= PARITY;
                     shreg <= {par ^ shreg[DATA_W-1], {(DATA_W-1){1'b0}}};
`else
                     state          <= IDLE;
                     shreg          <= '0;
                     ser_data_val_o <= 1'b0;
                     busy_o         <= 1'b0;
`endif
                  end else begin
                     shreg <= shreg << 1;
`ifdef SERIALIZER_PARITY_EN
                     par   <= par ^ shreg[DATA_W-1];
`endif
                  end
               end
            end
`ifdef SERIALIZER_PARITY_EN
            PARITY: begin
               if (ser_ready_i) begin
                  state          <= IDLE;
                  shreg          <= '0;
                  ser_data_val_o <= 1'b0;
                  busy_o         <= 1'b0;
               end
            end
`endif
            default: begin
               state          <= IDLE;
               shreg          <= '0;
               ser_data_val_o <= 1'b0;
               busy_o         <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: queue-based bit model plus
// hand-computed word and timing expectations.
module tb_serializer;

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic [15:0] data = '0;
   logic [3:0]  dmod = '0;
   logic        dval = 1'b0;
   logic        rdy = 1'b0;
   logic        sdo;
   logic        sval;
   logic        busy;

`ifdef SERIALIZER_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   int n_chk = 0;
   int n_fail = 0;
   bit mbits[$];
   bit cap[$];
   int drop;

   serializer dut (
      .clk_i         (clk),
      .arst_n_i      (arst_n),
      .data_i        (data),
      .data_mod_i    (dmod),
      .data_val_i    (dval),
      .ser_ready_i   (rdy),
      .ser_data_o    (sdo),
      .ser_data_val_o(sval),
      .busy_o        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the word becomes a list of bits to send; one leaves per ready.
   always @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         mbits.delete();
      end else if (mbits.size() > 0) begin
         if (rdy) void'(mbits.pop_front());
      end else if (dval) begin
         int n;
         bit p;
         n = (dmod == 0) ? 16 : int'(dmod);
         p = 1'b0;
         for (int i = 0; i < n; i++) begin
            mbits.push_back(data[15-i]);
            p ^= data[15-i];
         end
         if (PAR == 1) mbits.push_back(p);
      end
   end

   always @(negedge clk) begin
      check("val", sval, (mbits.size() > 0) ? 1 : 0);
      check("busy", busy, (mbits.size() > 0) ? 1 : 0);
      if (mbits.size() > 0) check("bit", sdo, mbits[0]);
      if (sval && rdy) cap.push_back(sdo);
   end

   task automatic send(input logic [15:0] w, input logic [3:0] m,
                       input int mode, input int inject, output int d);
      cap.delete();
      d = -1;
      @(posedge clk); #1;
      data = w; dmod = m; dval = 1'b1; rdy = 1'b1;
      @(posedge clk); #1;
      dval = 1'b0; data = 16'($urandom); dmod = 4'($urandom);
      for (int c = 0; c < 200; c++) begin
         rdy = (mode == 0) || (c % 3 == 0);
         dval = (c == inject);
         if (c == inject) begin
            data = 16'hFFFF;
            dmod = 4'd0;
         end
         @(posedge clk); #1;
         if (!busy) begin
            d = c + 2;
            break;
         end
      end
      dval = 1'b0;
      rdy = 1'b1;
      if (d < 0) check("timeout", busy, 0);
   endtask

   task automatic chk_cap(input string name, input logic [15:0] v,
                          input int n, input logic p);
      logic [31:0] ev;
      logic [31:0] av;
      int len;
      ev = 32'(v);
      len = n;
      if (PAR == 1) begin
         ev = {ev[30:0], p};
         len++;
      end
      av = '0;
      foreach (cap[i]) av = {av[30:0], cap[i]};
      check({name, "_len"}, cap.size(), len);
      check({name, "_bits"}, av, ev);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_sdo", sdo, 0);
      check("rst_val", sval, 0);
      check("rst_busy", busy, 0);
      arst_n = 1'b1;

      send(16'hA5C3, 4'd0, 0, -1, drop);
      chk_cap("a5c3", 16'hA5C3, 16, 1'b0);
      check("a5c3_drop", drop, 17 + PAR);

      send(16'hF000, 4'd3, 0, -1, drop);
      chk_cap("f000", 16'h0007, 3, 1'b1);
      check("f000_drop", drop, 4 + PAR);

      send(16'h8001, 4'd0, 1, -1, drop);
      chk_cap("stall", 16'h8001, 16, 1'b0);

      send(16'h5A5A, 4'd0, 0, 5, drop);
      chk_cap("ignore", 16'h5A5A, 16, 1'b0);
      check("ignore_drop", drop, 17 + PAR);

      // Abort 16'h1234 after five accepted bits.
      cap.delete();
      @(posedge clk); #1;
      data = 16'h1234; dmod = 4'd0; dval = 1'b1; rdy = 1'b1;
      @(posedge clk); #1;
      dval = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("pre_rst_busy", busy, 1);
      check("pre_rst_bits", cap.size(), 5);
      #1 arst_n = 1'b0;
      #1;
      check("mid_rst_sdo", sdo, 0);
      check("mid_rst_val", sval, 0);
      check("mid_rst_busy", busy, 0);
      @(negedge clk); #2;
      arst_n = 1'b1;

      send(16'h00FF, 4'd0, 0, -1, drop);
      chk_cap("00ff", 16'h00FF, 16, 1'b0);

      send(16'hE000, 4'd3, 0, -1, drop);
      chk_cap("e000", 16'h0007, 3, 1'b1);
      check("e000_drop", drop, 4 + PAR);

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
